// File: rtl/pe_wavefront_ctrl.sv
// ---------------------------------------------------------------------------
// pe_wavefront_ctrl
// Processor-enable sequencer for the systolic matmul array. A start pulse
// launches a staggered wavefront of PE enables: PE k rises k*S cycles after
// PE 0, each stays high for L cycles, and they fall in the same order. A
// one-cycle done pulse marks the first cycle with every enable low again.
//
// Optional feature macro: PE_STAGGER_STEP_EN
//   defined   -> 'step' port exists, stagger spacing S programmable (0 acts as 1)
//   undefined -> no 'step' port, S is fixed at 1
//
// Ports
//   clk         in   1                  clock, rising edge
//   rst         in   1                  asynchronous reset, active low
//   enable      in   1                  level; low aborts/clears on the next edge
//   start       in   1                  request, accepted only in IDLE with enable
//   mat_size    in   SIZE_W             PEs to activate (clamped to N_PE)
//   run_len     in   LEN_W              cycles each PE stays enabled (0 acts as 1)
//   step        in   STEP_W             stagger spacing (PE_STAGGER_STEP_EN only)
//   pe_en       out  N_PE               per-PE enable, registered
//   busy        out  1                  sequence in progress (incl. done cycle)
//   done        out  1                  one-cycle completion pulse
//   active_cnt  out  $clog2(N_PE+1)     popcount of pe_en, registered with it
// ---------------------------------------------------------------------------
module pe_wavefront_ctrl #(
    parameter int N_PE   = 4,
    parameter int SIZE_W = 4,
    parameter int LEN_W  = 8,
    parameter int STEP_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       start,
    input  logic [SIZE_W-1:0]          mat_size,
    input  logic [LEN_W-1:0]           run_len,
`ifdef PE_STAGGER_STEP_EN
    input  logic [STEP_W-1:0]          step,
`endif
    output logic [N_PE-1:0]            pe_en,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N_PE+1)-1:0]  active_cnt
);

    // Counter must cover the latest possible fall time without wrapping.
    localparam int CNT_MAX = (N_PE - 1) * ((1 << STEP_W) - 1) + (1 << LEN_W);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int N_W     = $clog2(N_PE + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [N_W-1:0]     r_n;
    logic [CNT_W-1:0]   r_l, r_s, r_end;

    logic [N_W-1:0]     w_n_in, w_n;
    logic [CNT_W-1:0]   w_l_in, w_s_in, w_end_in, w_l, w_s;
    logic               w_load, w_eval, w_busy_next, w_done_next;
    logic [N_PE-1:0]    w_pe_next;
    logic [N_W-1:0]     w_pop;

    // Sequence parameters as they would be latched by a start this cycle.
    always_comb begin
        w_n_in   = (int'(mat_size) > N_PE) ? N_W'(N_PE) : N_W'(mat_size);
        w_l_in   = (run_len == '0) ? CNT_W'(1) : CNT_W'(run_len);
`ifdef PE_STAGGER_STEP_EN
        w_s_in   = (step == '0) ? CNT_W'(1) : CNT_W'(step);
`else
        w_s_in   = CNT_W'(1);
`endif
        // Counter value of the done cycle: last PE's fall time.
        w_end_in = (w_n_in == '0) ? '0
                 : (CNT_W'(w_n_in) - CNT_W'(1)) * w_s_in + w_l_in;
    end

    // In IDLE the windows are evaluated for the launch edge, so use the
    // values being latched rather than the stale registers.
    assign w_n = (r_state == S_IDLE) ? w_n_in : r_n;
    assign w_l = (r_state == S_IDLE) ? w_l_in : r_l;
    assign w_s = (r_state == S_IDLE) ? w_s_in : r_s;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_load       = 1'b0;
        w_eval       = 1'b0;
        w_busy_next  = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && start) begin
                    w_cnt_next  = '0;
                    w_load      = 1'b1;
                    w_eval      = 1'b1;
                    w_busy_next = 1'b1;
                    if (w_end_in == '0) begin
                        // Zero PEs: the very first cycle is already the done cycle.
                        w_state_next = S_DONE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (r_cnt != CNT_W'(CNT_MAX))
                    w_cnt_next = r_cnt + CNT_W'(1);
                w_eval      = 1'b1;
                w_busy_next = 1'b1;
                if (w_cnt_next == r_end) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
        // Enable low overrides everything; no done pulse on abort.
        if (!enable) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
            w_eval       = 1'b0;
            w_busy_next  = 1'b0;
            w_done_next  = 1'b0;
        end
    end

    // Per-PE window compare against the next counter value, so pe_en is a
    // plain register with the window [k*S, k*S+L).
    generate
        for (genvar gi = 0; gi < N_PE; gi++) begin : g_pe
            logic [CNT_W-1:0] w_lo, w_hi;
            assign w_lo = CNT_W'(gi) * w_s;
            assign w_hi = w_lo + w_l;
            assign w_pe_next[gi] = w_eval && (N_W'(gi) < w_n)
                                && (w_cnt_next >= w_lo) && (w_cnt_next < w_hi);
        end
    endgenerate

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_PE; i++)
            w_pop = w_pop + N_W'(w_pe_next[i]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_n        <= '0;
            r_l        <= '0;
            r_s        <= '0;
            r_end      <= '0;
            pe_en      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            active_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            if (w_load) begin
                r_n   <= w_n_in;
                r_l   <= w_l_in;
                r_s   <= w_s_in;
                r_end <= w_end_in;
            end
            pe_en      <= w_pe_next;
            busy       <= w_busy_next;
            done       <= w_done_next;
            active_cnt <= w_pop;
        end
    end

endmodule

// File: tb/tb_pe_wavefront_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pe_wavefront_ctrl
// Scoreboard bench: the stimulus side updates a timeline model of the
// sequence (start cycle, n, L, S) on every clock edge and pushes the outputs
// expected for the following cycle; a monitor pops one entry per cycle at the
// falling edge and compares all outputs. Directed cases followed by random.
// ---------------------------------------------------------------------------
module tb_pe_wavefront_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       start;
    logic [3:0] mat_size;
    logic [7:0] run_len;
`ifdef PE_STAGGER_STEP_EN
    logic [2:0] step;
`endif
    logic [3:0] pe_en;
    logic       busy;
    logic       done;
    logic [2:0] active_cnt;

    pe_wavefront_ctrl #(.N_PE(4), .SIZE_W(4), .LEN_W(8), .STEP_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .start      (start),
        .mat_size   (mat_size),
        .run_len    (run_len),
`ifdef PE_STAGGER_STEP_EN
        .step       (step),
`endif
        .pe_en      (pe_en),
        .busy       (busy),
        .done       (done),
        .active_cnt (active_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] pe;
        logic       busy;
        logic       done;
        logic [2:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Timeline model state
    int cyc   = 0;
    bit m_act = 0;
    int m_T = 0, m_n = 0, m_L = 0, m_S = 1, m_end = 0;

    function automatic exp_t expect_at(int cy);
        exp_t e;
        int   c;
        e.pe = '0; e.busy = 0; e.done = 0; e.cnt = '0; e.cyc = cy;
        c = cy - (m_T + 1);
        if (m_act && c >= 0 && c <= m_end) begin
            for (int k = 0; k < 4; k++)
                e.pe[k] = (k < m_n) && (c >= k * m_S) && (c < k * m_S + m_L);
            e.busy = 1'b1;
            e.done = (c == m_end);
            e.cnt  = 3'($countones(e.pe));
        end
        return e;
    endfunction

    // Apply inputs for the current cycle, let the edge happen, then model it.
    task automatic tick(input bit en, input bit st, input int ms, input int rl, input int sp);
        int  c;
        bit  in_seq;
        enable   = en;
        start    = st;
        mat_size = 4'(ms);
        run_len  = 8'(rl);
`ifdef PE_STAGGER_STEP_EN
        step     = 3'(sp);
`endif
        @(posedge clk);
        #1;
        c      = cyc - (m_T + 1);
        in_seq = m_act && c >= 0 && c <= m_end;
        if (!rst || !en) begin
            m_act = 0;
        end else if (st && !in_seq) begin
            m_act = 1;
            m_T   = cyc;
            m_n   = (ms > 4) ? 4 : ms;
            m_L   = (rl == 0) ? 1 : rl;
`ifdef PE_STAGGER_STEP_EN
            m_S   = (sp == 0) ? 1 : sp;
`else
            m_S   = 1;
`endif
            m_end = (m_n == 0) ? 0 : (m_n - 1) * m_S + m_L;
        end
        cyc++;
        sb.push_back(expect_at(cyc));
    endtask

    // Asynchronous reset inside the current cycle: outputs clear at once.
    task automatic reset_now();
        exp_t e;
        rst   = 1'b0;
        m_act = 0;
        e = sb[$];
        sb.pop_back();
        e.pe = '0; e.busy = 0; e.done = 0; e.cnt = '0;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                if (pe_en !== e.pe) begin
                    n_err++;
                    $display("FAIL pe_en cyc=%0d got=%b exp=%b", e.cyc, pe_en, e.pe);
                end
                n_cmp++;
                if (busy !== e.busy) begin
                    n_err++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, busy, e.busy);
                end
                n_cmp++;
                if (done !== e.done) begin
                    n_err++;
                    $display("FAIL done cyc=%0d got=%b exp=%b", e.cyc, done, e.done);
                end
                n_cmp++;
                if (active_cnt !== e.cnt) begin
                    n_err++;
                    $display("FAIL active_cnt cyc=%0d got=%0d exp=%0d", e.cyc, active_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; enable = 1'b0; start = 1'b0; mat_size = '0; run_len = '0;
`ifdef PE_STAGGER_STEP_EN
        step = '0;
`endif
        // Reset state
        repeat (3) tick(0, 0, 0, 0, 0);
        rst = 1'b1;
        idle(2);

        // Case 1: mat_size=3, run_len=5
        tick(1, 1, 3, 5, 1); idle(12);
        $display("case1 mat_size=3 run_len=5 done");
        // Case 2: clamp mat_size=9, run_len=2
        tick(1, 1, 9, 2, 1); idle(10);
        $display("case2 mat_size=9 run_len=2 done");
        // Case 3: mat_size=0, then run_len=0
        tick(1, 1, 0, 5, 1); idle(4);
        tick(1, 1, 2, 0, 1); idle(6);
        $display("case3 mat_size=0 / run_len=0 done");
        // Extra start at T+3 ignored (case-1 timeline), changing inputs
        tick(1, 1, 3, 5, 1); idle(2); tick(1, 1, 4, 9, 1); idle(10);
        // Start in the done cycle ignored, next cycle accepted
        tick(1, 1, 1, 1, 1); tick(1, 0, 0, 0, 0); tick(1, 1, 2, 2, 1);
        tick(1, 1, 2, 2, 1); idle(8);
        $display("case4a start-while-busy/done done");
        // Case 4: mat_size=4, run_len=10, enable low at T+6
        tick(1, 1, 4, 10, 1); idle(5); tick(0, 0, 0, 0, 0); idle(6);
        // Start with enable low is ignored
        tick(0, 1, 3, 5, 1); idle(4);
        $display("case4 abort done");
        // Case 5: reset at T+4, then case 1 again
        tick(1, 1, 3, 5, 1); idle(3); reset_now();
        tick(1, 0, 0, 0, 0); tick(1, 0, 0, 0, 0);
        rst = 1'b1;
        idle(2); tick(1, 1, 3, 5, 1); idle(12);
        $display("case5 async reset done");
`ifdef PE_STAGGER_STEP_EN
        // Case 6: step=3
        tick(1, 1, 3, 4, 3); idle(14);
        tick(1, 1, 4, 1, 7); idle(25);
        tick(1, 1, 4, 3, 0); idle(10);
        $display("case6 step done");
`endif
        // Random
        for (int i = 0; i < 3000; i++) begin
            bit en, st;
            int ms, rl, sp;
            en = ($urandom_range(0, 99) < 96);
            st = ($urandom_range(0, 99) < 20);
            ms = $urandom_range(0, 15);
            rl = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
            sp = $urandom_range(0, 7);
            tick(en, st, ms, rl, sp);
            if ($urandom_range(0, 399) == 0) begin
                reset_now();
                tick(1, 0, 0, 0, 0);
                rst = 1'b1;
            end
        end
        $display("random phase done");
        idle(2);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
